// File: rtl/axi_r_responder_if.sv
// AR request, R response and memory-port signals of the AXI read responder.
// The slave modport is the responder; the master modport is the crossbar/memory side.
interface axi_r_responder_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]   ARID;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [ID_WIDTH-1:0]   RID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, mem_rdata, RREADY,
        output ARREADY, mem_re, mem_addr, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, mem_rdata, RREADY,
        input  ARREADY, mem_re, mem_addr, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_r_responder.sv
// Single-outstanding AXI read responder: one AR burst at a time, each beat fetched
// from a 1-cycle-latency memory and presented on R with fully registered outputs.
module axi_r_responder #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    axi_r_responder_if.slave  bus
);
    localparam int OFF = $clog2(DATA_WIDTH / 8);
    localparam logic [2:0] SIZE_MAX = 3'(OFF);
    localparam logic [ADDR_WIDTH-1:0] ZERO_A = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~((ONE_A << OFF) - ONE_A);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FETCH = 2'd1, ST_WAIT = 2'd2, ST_SEND = 2'd3} state_t;

    function automatic logic [ADDR_WIDTH-1:0] size_mask(input logic [2:0] size);
        return (ONE_A << size) - ONE_A;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [7:0] len,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] sz;
        logic [ADDR_WIDTH-1:0] wb;
        logic [ADDR_WIDTH-1:0] lo;
        logic [ADDR_WIDTH-1:0] na;
        sz = ONE_A << size;
        wb = (ADDR_WIDTH'(len) + ONE_A) << size;
        lo = addr & ~(wb - ONE_A);
        case (burst)
            2'b00:   na = addr;
            2'b01:   na = (addr & ~size_mask(size)) + sz;
            2'b10:   na = ((addr + sz) == (lo + wb)) ? lo : (addr + sz);
            default: na = addr;
        endcase
        return na;
    endfunction

    state_t                state_r, state_s;
    logic                  arready_r, arready_s;
    logic                  rvalid_r, rvalid_s;
    logic                  rlast_r, rlast_s;
    logic [1:0]            rresp_r, rresp_s;
    logic [ID_WIDTH-1:0]   rid_r, rid_s;
    logic [DATA_WIDTH-1:0] rdata_r, rdata_s;
    logic                  mem_re_r, mem_re_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [7:0]            len_r, len_s;
    logic [7:0]            beat_r, beat_s;
    logic [2:0]            size_r, size_s;
    logic [1:0]            burst_r, burst_s;
    logic                  err_r, err_s;
    logic                  req_err_s;
    logic [ADDR_WIDTH-1:0] adv_addr_s;

    // Request legality: reserved burst, oversize beat, bad WRAP length or alignment.
    always_comb begin
        req_err_s = 1'b0;
        if (bus.ARBURST == 2'b11) begin
            req_err_s = 1'b1;
        end else if (bus.ARSIZE > SIZE_MAX) begin
            req_err_s = 1'b1;
        end else if (bus.ARBURST == 2'b10) begin
            req_err_s = !((bus.ARLEN == 8'd1) || (bus.ARLEN == 8'd3) ||
                          (bus.ARLEN == 8'd7) || (bus.ARLEN == 8'd15)) ||
                        ((bus.ARADDR & size_mask(bus.ARSIZE)) != ZERO_A);
        end else begin
            req_err_s = 1'b0;
        end
    end

    assign adv_addr_s = next_addr(addr_r, size_r, len_r, burst_r);

    // Next-state and next-output logic; outputs hold unless a transition changes them.
    always_comb begin
        state_s    = state_r;
        arready_s  = arready_r;
        rvalid_s   = rvalid_r;
        rlast_s    = rlast_r;
        rresp_s    = rresp_r;
        rid_s      = rid_r;
        rdata_s    = rdata_r;
        mem_re_s   = 1'b0;
        mem_addr_s = mem_addr_r;
        addr_s     = addr_r;
        len_s      = len_r;
        beat_s     = beat_r;
        size_s     = size_r;
        burst_s    = burst_r;
        err_s      = err_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.ARVALID && arready_r) begin
                    arready_s = 1'b0;
                    rid_s     = bus.ARID;
                    addr_s    = bus.ARADDR;
                    len_s     = bus.ARLEN;
                    size_s    = bus.ARSIZE;
                    burst_s   = bus.ARBURST;
                    beat_s    = 8'd0;
                    err_s     = req_err_s;
                    if (req_err_s) begin
                        // Error bursts skip memory and present zero data immediately.
                        state_s  = ST_SEND;
                        rvalid_s = 1'b1;
                        rlast_s  = (bus.ARLEN == 8'd0);
                        rresp_s  = 2'b10;
                        rdata_s  = {DATA_WIDTH{1'b0}};
                    end else begin
                        state_s    = ST_FETCH;
                        rresp_s    = 2'b00;
                        mem_re_s   = 1'b1;
                        mem_addr_s = bus.ARADDR & WORD_MASK;
                    end
                end else begin
                    arready_s = 1'b1;
                end
            end
            ST_FETCH: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                state_s  = ST_SEND;
                rdata_s  = bus.mem_rdata;
                rvalid_s = 1'b1;
                rlast_s  = (beat_r == len_r);
            end
            ST_SEND: begin
                if (bus.RREADY) begin
                    if (rlast_r) begin
                        state_s   = ST_IDLE;
                        arready_s = 1'b1;
                        rvalid_s  = 1'b0;
                        rlast_s   = 1'b0;
                    end else begin
                        beat_s = beat_r + 8'd1;
                        addr_s = adv_addr_s;
                        if (err_r) begin
                            rlast_s = ((beat_r + 8'd1) == len_r);
                        end else begin
                            state_s    = ST_FETCH;
                            rvalid_s   = 1'b0;
                            rlast_s    = 1'b0;
                            mem_re_s   = 1'b1;
                            mem_addr_s = adv_addr_s & WORD_MASK;
                        end
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
            rresp_r    <= 2'b00;
            rid_r      <= {ID_WIDTH{1'b0}};
            rdata_r    <= {DATA_WIDTH{1'b0}};
            mem_re_r   <= 1'b0;
            mem_addr_r <= ZERO_A;
            addr_r     <= ZERO_A;
            len_r      <= 8'd0;
            beat_r     <= 8'd0;
            size_r     <= 3'd0;
            burst_r    <= 2'b00;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            arready_r  <= arready_s;
            rvalid_r   <= rvalid_s;
            rlast_r    <= rlast_s;
            rresp_r    <= rresp_s;
            rid_r      <= rid_s;
            rdata_r    <= rdata_s;
            mem_re_r   <= mem_re_s;
            mem_addr_r <= mem_addr_s;
            addr_r     <= addr_s;
            len_r      <= len_s;
            beat_r     <= beat_s;
            size_r     <= size_s;
            burst_r    <= burst_s;
            err_r      <= err_s;
        end
    end

    assign bus.ARREADY  = arready_r;
    assign bus.RVALID   = rvalid_r;
    assign bus.RLAST    = rlast_r;
    assign bus.RRESP    = rresp_r;
    assign bus.RID      = rid_r;
    assign bus.RDATA    = rdata_r;
    assign bus.mem_re   = mem_re_r;
    assign bus.mem_addr = mem_addr_r;
endmodule

// File: tb/tb_axi_r_responder.sv
// Bench for axi_r_responder: directed and random bursts against a beat-list model
// built from burst arithmetic, plus a memory model that returns address-derived data.
module tb_axi_r_responder;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    axi_r_responder_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

    axi_r_responder #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory: data valid the cycle after mem_re; garbage otherwise to expose mistimed capture.
    always @(posedge clk) begin
        if (bus.mem_re === 1'b1) bus.mem_rdata <= data_of(bus.mem_addr);
        else                     bus.mem_rdata <= $urandom;
    end

    task automatic do_burst(input string name, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input int mode);
        logic [31:0] szl, wbl, lo, a;
        logic        err;
        logic [31:0] exp_mem[$];
        logic [31:0] got_mem[$];
        beat_t       exp_b[$];
        beat_t       got_b[$];
        beat_t       eb, cur, prev;
        int          hs_cyc, first_cyc, last_acc, gap_bad, stab_bad, ardy_bad, hold;
        bit          hs, done, prev_valid, prev_acc;

        szl = 32'd1 << size;
        wbl = (32'(len) + 32'd1) * szl;
        err = (burst == 2'b11) || (szl > 32'd4) ||
              (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
              (burst == 2'b10 && (addr % szl) != 32'd0);
        for (int i = 0; i <= int'(len); i++) begin
            case (burst)
                2'b00:   a = addr;
                2'b01:   a = (i == 0) ? addr : (addr - addr % szl) + 32'(i) * szl;
                default: begin
                    lo = addr - addr % wbl;
                    a  = lo + ((addr - lo) + 32'(i) * szl) % wbl;
                end
            endcase
            eb.id   = id;
            eb.resp = err ? 2'b10 : 2'b00;
            eb.last = (i == int'(len));
            eb.data = err ? 32'd0 : data_of(a & 32'hFFFF_FFFC);
            exp_b.push_back(eb);
            if (!err) exp_mem.push_back(a & 32'hFFFF_FFFC);
        end

        @(posedge clk); #1;
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size; bus.ARBURST = burst;
        bus.ARVALID = 1'b1;
        hs = 1'b0;
        hs_cyc = 0;
        for (int t = 0; t < 20 && !hs; t++) begin
            @(negedge clk);
            if (bus.ARREADY === 1'b1) begin
                hs = 1'b1;
                hs_cyc = cyc + 1;
            end
        end
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        bus.ARID = 4'($urandom); bus.ARADDR = $urandom; bus.ARLEN = 8'($urandom);
        bus.ARSIZE = 3'($urandom); bus.ARBURST = 2'($urandom);
        if (!hs) begin
            n_checks++;
            $display("FAIL %s ar_handshake: ARREADY=%b, required 1 within 20 cycles", name, bus.ARREADY);
            return;
        end

        done = 1'b0; prev_valid = 1'b0; prev_acc = 1'b0; prev = '0;
        first_cyc = -1; last_acc = -1; gap_bad = 0; stab_bad = 0; ardy_bad = 0; hold = 0;
        for (int t = 0; t < 8 * (int'(len) + 1) + 40 && !done; t++) begin
            case (mode)
                0:       bus.RREADY = 1'b1;
                1:       bus.RREADY = ($urandom_range(0, 3) != 0);
                default: bus.RREADY = !(got_b.size() == 1 && hold < 5);
            endcase
            @(negedge clk);
            if (bus.mem_re === 1'b1) got_mem.push_back(bus.mem_addr);
            if (bus.ARREADY !== 1'b0) ardy_bad++;
            cur = {bus.RID, bus.RDATA, bus.RRESP, bus.RLAST};
            if (bus.RVALID === 1'b1) begin
                if (prev_valid && !prev_acc) begin
                    if (cur !== prev) stab_bad++;
                end else if (got_b.size() == 0) begin
                    first_cyc = cyc;
                end else if (cyc - last_acc != (err ? 1 : 3)) begin
                    gap_bad++;
                end
                if (bus.RREADY) begin
                    got_b.push_back(cur);
                    last_acc = cyc;
                    prev_acc = 1'b1;
                    if (bus.RLAST === 1'b1) done = 1'b1;
                end else begin
                    prev_acc = 1'b0;
                    if (got_b.size() == 1) hold++;
                end
            end else begin
                if (prev_valid && !prev_acc) stab_bad++;
                prev_acc = 1'b0;
            end
            prev_valid = (bus.RVALID === 1'b1);
            prev = cur;
            @(posedge clk); #1;
        end
        bus.RREADY = 1'b0;

        n_checks++;
        if (!done) $display("FAIL %s timeout: RLAST handshake seen=%b, required 1", name, done);
        else n_pass++;
        n_checks++;
        if (got_b.size() != exp_b.size())
            $display("FAIL %s beat_count: got %0d, expected %0d", name, got_b.size(), exp_b.size());
        else n_pass++;
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
            n_checks++;
            if (got_b[i] !== exp_b[i])
                $display("FAIL %s beat%0d: got id=%h data=%h resp=%b last=%b, expected id=%h data=%h resp=%b last=%b",
                         name, i, got_b[i].id, got_b[i].data, got_b[i].resp, got_b[i].last,
                         exp_b[i].id, exp_b[i].data, exp_b[i].resp, exp_b[i].last);
            else n_pass++;
        end
        n_checks++;
        if (got_mem.size() != exp_mem.size())
            $display("FAIL %s mem_re_count: got %0d, expected %0d", name, got_mem.size(), exp_mem.size());
        else n_pass++;
        for (int i = 0; i < got_mem.size() && i < exp_mem.size(); i++) begin
            n_checks++;
            if (got_mem[i] !== exp_mem[i])
                $display("FAIL %s mem_addr%0d: got %h, expected %h", name, i, got_mem[i], exp_mem[i]);
            else n_pass++;
        end
        n_checks++;
        if (first_cyc != hs_cyc + (err ? 0 : 2))
            $display("FAIL %s first_rvalid_latency: got %0d, expected %0d", name, first_cyc - hs_cyc, err ? 0 : 2);
        else n_pass++;
        n_checks++;
        if (gap_bad != 0 || stab_bad != 0 || ardy_bad != 0)
            $display("FAIL %s timing: gap_errs=%0d hold_errs=%0d arready_errs=%0d, expected 0/0/0",
                     name, gap_bad, stab_bad, ardy_bad);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.ARREADY !== 1'b1 || bus.RVALID !== 1'b0)
            $display("FAIL %s after_last: ARREADY=%b RVALID=%b, expected 1 0", name, bus.ARREADY, bus.RVALID);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.ARREADY, bus.RVALID, bus.RLAST, bus.RRESP, bus.RID, bus.RDATA, bus.mem_re, bus.mem_addr} !== 74'd0)
            $display("FAIL reset_values: ARREADY=%b RVALID=%b RLAST=%b RRESP=%b RID=%h RDATA=%h mem_re=%b mem_addr=%h, expected all 0",
                     bus.ARREADY, bus.RVALID, bus.RLAST, bus.RRESP, bus.RID, bus.RDATA, bus.mem_re, bus.mem_addr);
        else n_pass++;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (bus.ARREADY !== 1'b0) $display("FAIL reset_release_arready: got %b, expected 0", bus.ARREADY);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.ARREADY !== 1'b1) $display("FAIL reset_first_edge_arready: got %b, expected 1", bus.ARREADY);
        else n_pass++;
    endtask

    task automatic test_incr();
        do_burst("incr", 4'd3, 32'h0000_0100, 8'd3, 3'd2, 2'b01, 0);
    endtask

    task automatic test_wrap();
        do_burst("wrap", 4'd6, 32'h0000_0038, 8'd3, 3'd2, 2'b10, 0);
    endtask

    task automatic test_fixed();
        do_burst("fixed", 4'd8, 32'h0000_0020, 8'd2, 3'd2, 2'b00, 0);
    endtask

    task automatic test_error();
        do_burst("err_reserved", 4'd1, 32'h0000_0040, 8'd1, 3'd2, 2'b11, 0);
        do_burst("err_size", 4'd2, 32'h0000_0080, 8'd1, 3'd3, 2'b01, 0);
        do_burst("err_wrap_len", 4'd4, 32'h0000_0000, 8'd2, 3'd2, 2'b10, 1);
        do_burst("err_wrap_align", 4'd5, 32'h0000_0042, 8'd3, 3'd2, 2'b10, 1);
    endtask

    task automatic test_backpressure();
        do_burst("backpressure", 4'd7, 32'h0000_0400, 8'd3, 3'd2, 2'b01, 2);
    endtask

    task automatic test_max_len();
        do_burst("incr256_wrap32", 4'd15, 32'hFFFF_FF80, 8'd255, 3'd2, 2'b01, 0);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  b;
        logic [2:0]  s;
        logic [7:0]  l;
        logic [31:0] a;
        int          r;
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            b = (r == 0) ? 2'b11 : (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : 2'b00;
            s = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            a = $urandom;
            if (b == 2'b10) begin
                l = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 15))
                                                : (8'd1 << $urandom_range(1, 4)) - 8'd1;
                if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << s) - 32'd1);
            end else begin
                l = 8'($urandom_range(0, 15));
            end
            do_burst("random", 4'($urandom), a, l, s, b, 1);
        end
    endtask

    task automatic test_reset_mid_burst();
        int rises;
        int stray;
        bit seen, pv;
        @(posedge clk); #1;
        bus.ARID = 4'd5; bus.ARADDR = 32'h0000_0200; bus.ARLEN = 8'd7; bus.ARSIZE = 3'd2;
        bus.ARBURST = 2'b01; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
        rises = 0; seen = 1'b0; pv = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (bus.RVALID === 1'b1 && !pv) rises++;
            pv = (bus.RVALID === 1'b1);
            if (rises == 2) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                if (bus.ARREADY === 1'b0) bus.ARVALID = 1'b0;
            end
        end
        bus.ARVALID = 1'b0;
        n_checks++;
        if (!seen) $display("FAIL rst_mid_setup: beat-2 RVALID rises=%0d, expected 2", rises);
        else n_pass++;
        #2 rst = 1'b1;
        bus.RREADY = 1'b0;
        #1;
        n_checks++;
        if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b0 || bus.mem_re !== 1'b0)
            $display("FAIL rst_mid_async: RVALID=%b ARREADY=%b mem_re=%b, expected 0 0 0", bus.RVALID, bus.ARREADY, bus.mem_re);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b0)
            $display("FAIL rst_mid_held: RVALID=%b ARREADY=%b, expected 0 0", bus.RVALID, bus.ARREADY);
        else n_pass++;
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.ARREADY !== 1'b1) $display("FAIL rst_mid_release_arready: got %b, expected 1", bus.ARREADY);
        else n_pass++;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.RVALID !== 1'b0 || bus.mem_re !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) $display("FAIL rst_mid_abandoned: stray RVALID/mem_re cycles=%0d, expected 0", stray);
        else n_pass++;
        do_burst("after_reset_single", 4'd9, 32'h0000_0300, 8'd0, 3'd2, 2'b01, 0);
    endtask

    initial begin
        bus.ARID = 4'd0; bus.ARADDR = 32'd0; bus.ARLEN = 8'd0; bus.ARSIZE = 3'd0; bus.ARBURST = 2'b00;
        bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
        test_reset();
        test_incr();
        test_wrap();
        test_fixed();
        test_error();
        test_backpressure();
        test_max_len();
        test_back_to_back();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
